// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS-style front end.
// Used by fetch_stage and its IF/ID register.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: async reset, synchronous clear, enable.
// Clear wins over enable so a flush always injects a NOP bubble.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  input  logic        valid_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  if_id_t q_q;
  if_id_t q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '{instr: NOP_INSTR, pc_plus4: 32'd0, valid: 1'b0};
    end else if (en_i) begin
      q_d = '{instr: instr_i, pc_plus4: pc_plus4_i, valid: valid_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '{instr: NOP_INSTR, pc_plus4: 32'd0, valid: 1'b0};
    end else begin
      q_q <= q_d;
    end
  end

  assign instr_o    = q_q.instr;
  assign pc_plus4_o = q_q.pc_plus4;
  assign valid_o    = q_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with single-outstanding imem and IF/ID register.
// Optional saturating perf counters when FETCH_PERF_EN is defined.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic        JumpD,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] PCJumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        ImissF
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] miss_cnt
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         redirect;
  logic         active;
  logic         accept;
  logic         ifid_en;
  logic [31:0]  ifid_instr;
  logic [31:0]  ifid_pcp4;

  assign redirect = (PCSrcD | JumpD) & ~StallD;
  assign target   = PCSrcD ? PCBranchD : PCJumpD;
  assign active   = (state_q != DROP);
  assign pc_plus4 = pcf_q + 32'd4;
  assign accept   = active & imem_valid & ~StallF;

  assign imem_req  = active;
  assign imem_addr = pcf_q;
  assign ImissF    = (active & ~imem_valid) | (state_q == DROP);

  always_comb begin
    pcf_d = pcf_q;
    if (redirect) begin
      pcf_d = target;
    end else if (StallF) begin
      pcf_d = pcf_q;
    end else if (active & imem_valid) begin
      pcf_d = pc_plus4;
    end
  end

  // The response in flight when a redirect lands belongs to the old PC,
  // so DROP swallows it before fetching the new target.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH, WAIT: begin
        if (imem_valid)    state_d = FETCH;
        else if (redirect) state_d = DROP;
        else               state_d = WAIT;
      end
      DROP: begin
        if (imem_valid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pcf_q   <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
    end
  end

  assign ifid_en    = ~StallD;
  assign ifid_instr = accept ? imem_rdata : NOP_INSTR;
  assign ifid_pcp4  = accept ? pc_plus4 : 32'd0;

  if_id_reg u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (ifid_en),
    .clr_i      (redirect),
    .instr_i    (ifid_instr),
    .pc_plus4_i (ifid_pcp4),
    .valid_i    (accept),
    .instr_o    (InstrD),
    .pc_plus4_o (PCPlus4D),
    .valid_o    (ValidD)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, miss_cnt_q;
  logic [31:0] stall_cnt_d, flush_cnt_d, miss_cnt_d;

  always_comb begin
    stall_cnt_d = StallF   ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = redirect ? sat_inc(flush_cnt_q) : flush_cnt_q;
    miss_cnt_d  = ImissF   ? sat_inc(miss_cnt_q)  : miss_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
      miss_cnt_q  <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign miss_cnt  = miss_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallF = 1'b0, StallD = 1'b0;
  logic        PCSrcD = 1'b0, JumpD = 1'b0;
  logic [31:0] PCBranchD = '0, PCJumpD = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic [31:0] InstrD, PCPlus4D;
  logic        ValidD, ImissF;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, miss_cnt;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: PC, whether the outstanding response is stale,
  // and the IF/ID contents.
  logic [31:0] m_pc;
  logic        m_stale;
  logic [31:0] m_instr, m_pcp4;
  logic        m_valid;
  int unsigned m_stall, m_flush, m_miss;

  fetch_stage #(.RESET_VECTOR(RV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .StallF     (StallF),
    .StallD     (StallD),
    .PCSrcD     (PCSrcD),
    .JumpD      (JumpD),
    .PCBranchD  (PCBranchD),
    .PCJumpD    (PCJumpD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .InstrD     (InstrD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .ImissF     (ImissF)
`ifdef FETCH_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = RV; m_stale = 1'b0;
    m_instr = '0; m_pcp4 = '0; m_valid = 1'b0;
    m_stall = 0; m_flush = 0; m_miss = 0;
  endtask

  task automatic clear_inputs();
    StallF = 0; StallD = 0; PCSrcD = 0; JumpD = 0;
    PCBranchD = '0; PCJumpD = '0; imem_valid = 0; imem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    #2;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Advance one clock; the model consumes the inputs present now.
  task automatic tick();
    logic        redir, useful, take;
    logic [31:0] tgt, n_pc, n_instr, n_pcp4;
    logic        n_stale, n_valid;
    redir  = (PCSrcD || JumpD) && !StallD;
    tgt    = PCSrcD ? PCBranchD : PCJumpD;
    useful = !m_stale && imem_valid;
    take   = useful && !StallF;
    if (redir)        n_pc = tgt;
    else if (StallF)  n_pc = m_pc;
    else if (useful)  n_pc = m_pc + 32'd4;
    else              n_pc = m_pc;
    if (redir) begin
      n_instr = 0; n_pcp4 = 0; n_valid = 0;
    end else if (StallD) begin
      n_instr = m_instr; n_pcp4 = m_pcp4; n_valid = m_valid;
    end else if (take) begin
      n_instr = imem_rdata; n_pcp4 = m_pc + 32'd4; n_valid = 1;
    end else begin
      n_instr = 0; n_pcp4 = 0; n_valid = 0;
    end
    if (imem_valid) n_stale = 1'b0;
    else            n_stale = m_stale || redir;
    if (StallF) m_stall++;
    if (redir) m_flush++;
    if (m_stale || !imem_valid) m_miss++;
    @(posedge clk);
    m_pc = n_pc; m_stale = n_stale;
    m_instr = n_instr; m_pcp4 = n_pcp4; m_valid = n_valid;
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (imem_addr !== RV) begin
      n_fail++; $display("FAIL reset_addr got %h want %h", imem_addr, RV);
    end
    n_cmp++;
    if (ValidD !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b want 0", ValidD);
    end
    n_cmp++;
    if (InstrD !== 32'h0) begin
      n_fail++; $display("FAIL reset_instr got %h want 0", InstrD);
    end
    n_cmp++;
    if (PCPlus4D !== 32'h0) begin
      n_fail++; $display("FAIL reset_pcp4 got %h want 0", PCPlus4D);
    end
    n_cmp++;
    if (imem_req !== 1'b1 || ImissF !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_req_miss got %b%b want 11", imem_req, ImissF);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] prev;
    do_reset();
    prev = '0;
    for (int i = 0; i < 4; i++) begin
      imem_valid = 1;
      imem_rdata = $urandom;
      #1;
      n_cmp++;
      if (imem_addr !== 32'(i * 4)) begin
        n_fail++;
        $display("FAIL seq_addr%0d got %h want %h", i, imem_addr, 32'(i * 4));
      end
      n_cmp++;
      if (ValidD !== (i > 0) || (i > 0 && InstrD !== prev)) begin
        n_fail++;
        $display("FAIL seq_instr%0d got %b/%h want %b/%h",
                 i, ValidD, InstrD, i > 0, prev);
      end
      prev = imem_rdata;
      tick();
    end
  endtask

  task automatic test_branch();
    PCSrcD = 1; PCBranchD = 32'h40; imem_valid = 1;
    tick();
    PCSrcD = 0;
    n_cmp++;
    if (imem_addr !== 32'h40 || ValidD !== 1'b0 || InstrD !== 32'h0) begin
      n_fail++;
      $display("FAIL branch got pc=%h v=%b i=%h want pc=40 v=0 i=0",
               imem_addr, ValidD, InstrD);
    end
  endtask

  task automatic test_miss();
    logic [31:0] w;
    do_reset();
    imem_valid = 1;
    tick();
    tick();
    imem_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (ImissF !== 1'b1 || imem_addr !== 32'h8) begin
        n_fail++;
        $display("FAIL miss_wait%0d got miss=%b pc=%h want 1/8",
                 i, ImissF, imem_addr);
      end
      tick();
      n_cmp++;
      if (ValidD !== 1'b0) begin
        n_fail++; $display("FAIL miss_bubble%0d got %b want 0", i, ValidD);
      end
    end
    w = $urandom;
    imem_valid = 1; imem_rdata = w;
    #1;
    n_cmp++;
    if (ImissF !== 1'b0) begin
      n_fail++; $display("FAIL miss_release got %b want 0", ImissF);
    end
    tick();
    n_cmp++;
    if (ValidD !== 1'b1 || InstrD !== w || PCPlus4D !== 32'hC) begin
      n_fail++;
      $display("FAIL miss_accept got %b/%h/%h want 1/%h/c",
               ValidD, InstrD, PCPlus4D, w);
    end
  endtask

  task automatic test_jump_in_wait();
    logic [31:0] stale, good;
    do_reset();
    imem_valid = 0;
    tick();
    JumpD = 1; PCJumpD = 32'h100;
    tick();
    JumpD = 0;
    n_cmp++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h100 || ImissF !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_enter got req=%b pc=%h miss=%b want 0/100/1",
               imem_req, imem_addr, ImissF);
    end
    stale = $urandom;
    good  = stale ^ 32'h1;
    imem_valid = 1; imem_rdata = stale;
    tick();
    n_cmp++;
    if (ValidD !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL drop_discard got v=%b req=%b pc=%h want 0/1/100",
               ValidD, imem_req, imem_addr);
    end
    imem_rdata = good;
    tick();
    n_cmp++;
    if (InstrD !== good || PCPlus4D !== 32'h104 || ValidD !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_refetch got %h/%h want %h/104",
               InstrD, PCPlus4D, good);
    end
  endtask

  task automatic test_stall();
    logic [31:0] w1, w2;
    do_reset();
    imem_valid = 1;
    imem_rdata = $urandom;
    tick();
    w1 = $urandom;
    imem_rdata = w1;
    tick();
    StallF = 1; StallD = 1;
    for (int i = 0; i < 2; i++) begin
      imem_rdata = $urandom;
      tick();
      n_cmp++;
      if (imem_addr !== 32'h8 || InstrD !== w1) begin
        n_fail++;
        $display("FAIL stall_hold%0d got pc=%h i=%h want 8/%h",
                 i, imem_addr, InstrD, w1);
      end
    end
    StallF = 0; StallD = 0;
    w2 = $urandom;
    imem_rdata = w2;
    tick();
    n_cmp++;
    if (InstrD !== w2 || PCPlus4D !== 32'hC || imem_addr !== 32'hC) begin
      n_fail++;
      $display("FAIL stall_refetch got i=%h p4=%h pc=%h want %h/c/c",
               InstrD, PCPlus4D, imem_addr, w2);
    end
  endtask

  task automatic test_stalld_blocks_redirect();
    do_reset();
    imem_valid = 1;
    tick();
    PCSrcD = 1; PCBranchD = 32'h40; StallD = 1; StallF = 1;
    tick();
    n_cmp++;
    if (imem_addr !== 32'h4 || ValidD !== 1'b1) begin
      n_fail++;
      $display("FAIL stalld_redirect got pc=%h v=%b want 4/1",
               imem_addr, ValidD);
    end
    clear_inputs();
  endtask

  task automatic test_reset_in_drop();
    logic [31:0] w;
    do_reset();
    imem_valid = 0;
    tick();
    JumpD = 1; PCJumpD = 32'h200;
    tick();
    JumpD = 0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (imem_addr !== RV || imem_req !== 1'b1 || ValidD !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got pc=%h req=%b v=%b want %h/1/0",
               imem_addr, imem_req, ValidD, RV);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    w = $urandom;
    imem_valid = 1; imem_rdata = w;
    tick();
    n_cmp++;
    if (InstrD !== w || PCPlus4D !== RV + 32'd4 || ValidD !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_resp got %h/%h want %h/%h",
               InstrD, PCPlus4D, w, RV + 32'd4);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    imem_valid = 1;
    JumpD = 1; PCJumpD = 32'hFFFF_FFFC;
    tick();
    JumpD = 0;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    n_cmp++;
    if (imem_addr !== 32'h0 || PCPlus4D !== 32'h0 || ValidD !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap got pc=%h p4=%h v=%b want 0/0/1",
               imem_addr, PCPlus4D, ValidD);
    end
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      imem_valid = ($urandom_range(0, 3) != 0);
      imem_rdata = $urandom;
      StallF     = ($urandom_range(0, 5) == 0);
      StallD     = StallF && ($urandom_range(0, 1) == 0);
      PCSrcD     = ($urandom_range(0, 9) == 0);
      JumpD      = ($urandom_range(0, 11) == 0);
      PCBranchD  = {$urandom_range(0, 255), 2'b00};
      PCJumpD    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC
                                               : {$urandom, 2'b00} >> 2 << 2;
      #1;
      n_cmp++;
      if (imem_addr !== m_pc || imem_req !== !m_stale ||
          ImissF !== (m_stale || !imem_valid)) begin
        n_fail++;
        if (errs++ < 10)
          $display("FAIL rand_if%0d got %h/%b/%b want %h/%b/%b", i,
                   imem_addr, imem_req, ImissF,
                   m_pc, !m_stale, m_stale || !imem_valid);
      end
      tick();
      n_cmp++;
      if (InstrD !== m_instr || PCPlus4D !== m_pcp4 || ValidD !== m_valid) begin
        n_fail++;
        if (errs++ < 10)
          $display("FAIL rand_id%0d got %h/%h/%b want %h/%h/%b", i,
                   InstrD, PCPlus4D, ValidD, m_instr, m_pcp4, m_valid);
      end
    end
`ifdef FETCH_PERF_EN
    n_cmp++;
    if (stall_cnt !== 32'(m_stall) || flush_cnt !== 32'(m_flush) ||
        miss_cnt !== 32'(m_miss)) begin
      n_fail++;
      $display("FAIL perf_cnt got %0d/%0d/%0d want %0d/%0d/%0d",
               stall_cnt, flush_cnt, miss_cnt, m_stall, m_flush, m_miss);
    end
`endif
    clear_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_branch();
    test_miss();
    test_jump_in_wait();
    test_stall();
    test_stalld_blocks_redirect();
    test_reset_in_drop();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
